// File: rtl/seconds_timer.sv
// seconds_timer: seconds stage of the stopwatch/countdown timer; sets a 0..MAX_SEC preset, counts it down, borrows from minutes
module seconds_timer #(
    parameter int MAX_SEC = 59,
    parameter int W = 6
) (
    input  logic         clk_1Hz,
    input  logic         reset,
    input  logic         enable,
    input  logic         forward,
    input  logic         increment,
    input  logic         minutes_zero,
    output logic [W-1:0] seconds,
    output logic         minute_borrow,
    output logic         finish
);
    localparam logic [1:0] SET  = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    logic [1:0]   state;
    logic [W-1:0] set_val, cnt, set_nxt;
    always_comb begin
        set_nxt = increment ? ((set_val == W'(MAX_SEC)) ? '0 : set_val + W'(1)) : set_val;
        seconds = (state == SET) ? set_val : cnt;
    end
    always_ff @(posedge clk_1Hz) begin
        if (reset) begin
            set_val       <= '0;
            cnt           <= '0;
            state         <= SET;
            finish        <= 1'b0;
            minute_borrow <= 1'b0;
        end else if (!enable) begin
            minute_borrow <= 1'b0;
        end else begin
            minute_borrow <= 1'b0;
            case (state)
                SET: begin
                    set_val <= set_nxt;
                    cnt     <= set_nxt;
                    if (!forward) state <= RUN;
                end
                RUN: begin
                    if (forward) begin
                        state <= SET;
                    end else if (cnt != '0) begin
                        cnt <= cnt - W'(1);
                    end else if (!minutes_zero) begin
                        cnt           <= W'(MAX_SEC);
                        minute_borrow <= 1'b1;
                    end else begin
                        state  <= DONE;
                        finish <= 1'b1;
                    end
                end
                DONE: begin
                    cnt <= '0;
                    if (forward) begin
                        state  <= SET;
                        finish <= 1'b0;
                    end
                end
                default: state <= SET;
            endcase
        end
    end
endmodule

// File: tb/tb_seconds_timer.sv
// tb_seconds_timer: directed vector table plus hand sequences for seconds_timer
module tb_seconds_timer;
    logic       clk_1Hz = 1'b0;
    logic       reset = 1'b1, enable = 1'b0, forward = 1'b1, increment = 1'b0, minutes_zero = 1'b0;
    logic [5:0] seconds;
    logic       minute_borrow, finish;
    int         errors = 0;
    int         checks = 0;

    seconds_timer dut (
        .clk_1Hz(clk_1Hz), .reset(reset), .enable(enable), .forward(forward),
        .increment(increment), .minutes_zero(minutes_zero),
        .seconds(seconds), .minute_borrow(minute_borrow), .finish(finish)
    );

    always #5 clk_1Hz = ~clk_1Hz;

    // in = {reset, enable, forward, increment, minutes_zero}; o = {minute_borrow, finish}
    typedef struct {
        logic [4:0] in;
        logic [5:0] s;
        logic [1:0] o;
    } vec_t;
    vec_t tv[32];

    task automatic tick(input logic [4:0] in);
        {reset, enable, forward, increment, minutes_zero} = in;
        @(posedge clk_1Hz);
        #1;
    endtask

    task automatic chk(input string nm, input logic [5:0] es, input logic [1:0] eo);
        checks++;
        if (seconds !== es || {minute_borrow, finish} !== eo) begin
            errors++;
            $display("FAIL %s: got seconds=%0d borrow=%b finish=%b, expected seconds=%0d borrow=%b finish=%b",
                     nm, seconds, minute_borrow, finish, es, eo[1], eo[0]);
        end
    endtask

    initial begin
        tv = '{
            '{5'b11100, 6'd0,  2'b00}, '{5'b01110, 6'd1,  2'b00}, '{5'b01110, 6'd2,  2'b00},
            '{5'b01110, 6'd3,  2'b00}, '{5'b01001, 6'd3,  2'b00}, '{5'b01001, 6'd2,  2'b00},
            '{5'b01001, 6'd1,  2'b00}, '{5'b01001, 6'd0,  2'b00}, '{5'b01001, 6'd0,  2'b01},
            '{5'b01011, 6'd0,  2'b01}, '{5'b01000, 6'd0,  2'b01}, '{5'b01001, 6'd0,  2'b01},
            '{5'b00001, 6'd0,  2'b01}, '{5'b01100, 6'd3,  2'b00}, '{5'b11111, 6'd0,  2'b00},
            '{5'b01110, 6'd1,  2'b00}, '{5'b01000, 6'd1,  2'b00}, '{5'b01000, 6'd0,  2'b00},
            '{5'b01000, 6'd59, 2'b10}, '{5'b00000, 6'd59, 2'b00}, '{5'b01011, 6'd58, 2'b00},
            '{5'b01101, 6'd1,  2'b00}, '{5'b01001, 6'd1,  2'b00}, '{5'b01001, 6'd0,  2'b00},
            '{5'b01101, 6'd1,  2'b00}, '{5'b10000, 6'd0,  2'b00}, '{5'b01001, 6'd0,  2'b00},
            '{5'b01001, 6'd0,  2'b01}, '{5'b11001, 6'd0,  2'b00}, '{5'b01110, 6'd1,  2'b00},
            '{5'b00110, 6'd1,  2'b00}, '{5'b01110, 6'd2,  2'b00}
        };
        #2;
        tick(5'b11100);
        chk("reset", 6'd0, 2'b00);
        for (int i = 0; i < 61; i++) begin
            tick(5'b01110);
            chk($sformatf("preset_wrap[%0d]", i), 6'((i + 1) % 60), 2'b00);
        end
        for (int k = 0; k < 32; k++) begin
            tick(tv[k].in);
            chk($sformatf("vec[%0d]", k), tv[k].s, tv[k].o);
        end
        // preset 21, run to 20, pause, resume, then reset mid-run at 7
        tick(5'b11100);
        for (int i = 0; i < 21; i++) tick(5'b01110);
        chk("preset21", 6'd21, 2'b00);
        tick(5'b01000);
        chk("run_entry", 6'd21, 2'b00);
        tick(5'b01000);
        chk("run_20", 6'd20, 2'b00);
        for (int i = 0; i < 4; i++) begin
            tick(5'b00000);
            chk($sformatf("hold[%0d]", i), 6'd20, 2'b00);
        end
        for (int i = 0; i < 13; i++) begin
            tick(5'b01000);
            chk($sformatf("count[%0d]", i), 6'(19 - i), 2'b00);
        end
        tick(5'b11000);
        chk("reset_mid_run", 6'd0, 2'b00);
        tick(5'b01110);
        chk("inc_after_reset", 6'd1, 2'b00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seconds_timer.md
# seconds_timer

Seconds stage of the stopwatch/countdown timer, directly upstream of the minutes counter. In set mode (`forward`=1) it accumulates a preset 0–59 from the `increment` input. In run mode (`forward`=0) it counts that preset down once per second, reloads 59 while the minutes stage is non-zero, and raises `finish` at 00:00. Its `seconds` output is the value the minutes stage watches to decide when to decrement.

## Interface
- `MAX_SEC`, default 59: wrap/reload value for seconds.
- `W`, default 6: width of the seconds value; must hold `MAX_SEC`.

Ports:
- `clk_1Hz`  in  1  timer clock, one tick per second.
- `reset`  in  1  synchronous, active-high; clock `clk_1Hz`.
- `enable`  in  1  tick qualifier; when 0 all state and registers hold.
- `forward`  in  1  1 = set mode, 0 = run (countdown) mode.
- `increment`  in  1  level, debounced upstream; each enabled tick in SET with `increment`=1 advances the preset by 1.
- `minutes_zero`  in  1  1 when the minutes stage value is 0.
- `seconds`  out  W  current displayed seconds value.
- `minute_borrow`  out  1  registered one-tick pulse; minutes stage decrements on it.
- `finish`  out  1  registered; high while countdown has completed.

## Operation
- Registers: `set_val[W-1:0]`, `cnt[W-1:0]`, `state` ∈ {SET, RUN, DONE}, `finish`, `minute_borrow`.
- Reset has priority over everything: `set_val`=0, `cnt`=0, `state`=SET, `finish`=0, `minute_borrow`=0. `seconds` therefore reads 0.
- If `enable`=0 and `reset`=0, everything holds, and `minute_borrow` is forced to 0 on that tick.
- SET state:
  - If `increment`=1: `set_val` ← (`set_val`==`MAX_SEC`) ? 0 : `set_val`+1.
  - `cnt` ← the next value of `set_val`, so it mirrors the preset.
  - If `forward`=0: go to RUN. The transition tick performs no decrement.
- RUN state (evaluated in order):
  - `forward`=1: go to SET; `cnt` and `set_val` unchanged.
  - `cnt`≠0: `cnt` ← `cnt`−1.
  - `cnt`=0 and `minutes_zero`=0: `cnt` ← `MAX_SEC`; `minute_borrow` ← 1.
  - `cnt`=0 and `minutes_zero`=1: go to DONE; `finish` ← 1; `cnt` stays 0.
- DONE state: `cnt` holds at 0 and `finish` stays 1. If `forward`=1: go to SET and `finish` ← 0.
- `increment` is ignored outside SET. `minutes_zero` is ignored outside RUN.
- `minute_borrow` is 0 on every tick not listed above as setting it.
- `seconds` output is a combinational mux of registers: `set_val` in SET, `cnt` in RUN/DONE. It never exceeds `MAX_SEC`.
- A preset of 0 with `minutes_zero`=1 reaches DONE on the first RUN tick.

## Timing
- All register updates occur on the `clk_1Hz` rising edge.
- `seconds` changes in the same cycle as its source register.
- Increment latency: the `set_val` increment is visible on `seconds` one tick after `increment` is sampled high.
- Countdown from preset N to 0 takes N enabled RUN ticks after the SET→RUN tick.
- Wrap from 0 to `MAX_SEC` and `minute_borrow` occur on the same edge. The minutes stage sees `seconds`=0 for exactly one tick before the reload.
- Simultaneous `reset`=1 with any other input: the reset result wins.
- Simultaneous `forward`=1 with `cnt`=0 in RUN: go to SET; no borrow and no `finish`.
- Reset mid-run: next tick shows `seconds`=0 and `finish`=0, in SET state.

## Test plan
- Reset, then `forward`=1, `increment`=1 for 61 ticks → `seconds` goes 1..59, 0, 1; `finish`=0 throughout.
- Preset 3, `forward`→0, `minutes_zero`=1 → `seconds` reads 3 (transition tick), 2, 1, 0; `finish`=1 on the tick after `seconds` first reads 0; then holds 0/1 for 5 further ticks.
- Preset 1, `minutes_zero`=0 for the first wrap → `seconds` 1, 0, 59 with `minute_borrow`=1 exactly on the 0→59 edge; then `minutes_zero`=1, count to 0 → `finish`=1 with no borrow.
- `enable`=0 for 4 ticks mid-countdown at `seconds`=20 → value stays 20, no borrow; resumes 19 on the first enabled tick.
- `reset` asserted at `seconds`=7 in RUN, and separately in DONE → next tick `seconds`=0, `finish`=0, `minute_borrow`=0; a subsequent `increment` yields 1.
- In DONE, set `forward`=1 → `finish`=0 on the next tick and `seconds` shows the retained preset (e.g. 3); `increment` during RUN/DONE has no effect.
